// File: rtl/commit_trace_tx.sv
// ============================================================================
// Module      : commit_trace_tx
// Description : Buffers register-writeback commits (pc, reg, data) in a FIFO
//               and serializes each as a 9-byte record on a valid/ready stream.
//               Optional build macro: TRACE_FILTER_R0_EN (drop $0 writes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_tx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_en,
  input  logic [31:0] commit_pc,
  input  logic [4:0]  commit_reg,
  input  logic [31:0] commit_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);
  localparam logic [3:0]  c_last_idx   = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        r_state;
  logic [68:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [71:0]   r_shift;
  logic [3:0]    r_idx;
  logic          r_tx_valid;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic          w_commit;
  logic          w_at_full;
  logic          w_push;
  logic          w_drop;
  logic          w_accept;
  logic          w_last;
  logic          w_pop;
  logic [68:0]   w_head;
  logic [71:0]   w_head_bytes;
  logic [AW:0]   w_count_nxt;

`ifdef TRACE_FILTER_R0_EN
  assign w_commit = commit_en && (commit_reg != 5'd0);
`else
  assign w_commit = commit_en;
`endif

  // A full FIFO drops the commit even if a pop frees a slot on the same edge.
  assign w_at_full    = (r_count == c_full_count);
  assign w_push       = w_commit && !w_at_full;
  assign w_drop       = w_commit && w_at_full;
  assign w_accept     = r_tx_valid && tx_ready;
  assign w_last       = w_accept && (r_idx == c_last_idx);
  assign w_pop        = (r_count != '0) && ((r_state == ST_IDLE) || w_last);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_bytes = {w_head[68:37], 3'b000, w_head[36:32], w_head[31:0]};
  assign w_count_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {commit_pc, commit_reg, commit_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_full_count);
      r_empty <= (w_count_nxt == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // The shift register empties itself after the ninth byte, so tx_data idles at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 4'd0;
      r_shift    <= 72'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift    <= w_head_bytes;
            r_idx      <= 4'd0;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (r_idx != c_last_idx) begin
              r_idx   <= r_idx + 4'd1;
              r_shift <= {r_shift[63:0], 8'h00};
            end else if (w_pop) begin
              r_shift <= w_head_bytes;
              r_idx   <= 4'd0;
            end else begin
              r_shift    <= 72'd0;
              r_idx      <= 4'd0;
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_shift[71:64];
  assign tx_valid = r_tx_valid;
  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
// ============================================================================
// Module      : tb_commit_trace_tx
// Description : Scoreboard bench for commit_trace_tx (expected stream bytes are
//               queued as commits are driven and popped as bytes are accepted).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_commit_trace_tx;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        commit_en = 1'b0;
  logic [31:0] commit_pc = 32'd0;
  logic [4:0]  commit_reg = 5'd0;
  logic [31:0] commit_data = 32'd0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_b;

  commit_trace_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .commit_en(commit_en), .commit_pc(commit_pc),
    .commit_reg(commit_reg), .commit_data(commit_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_record(input logic [31:0] pc, input logic [4:0] rg,
                                      input logic [31:0] d);
    sb.push_back(pc[31:24]); sb.push_back(pc[23:16]);
    sb.push_back(pc[15:8]);  sb.push_back(pc[7:0]);
    sb.push_back({3'b000, rg});
    sb.push_back(d[31:24]);  sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);   sb.push_back(d[7:0]);
  endfunction

  task automatic drive_commit(input logic [31:0] pc, input logic [4:0] rg,
                              input logic [31:0] d, input bit keep);
    commit_en   = 1'b1;
    commit_pc   = pc;
    commit_reg  = rg;
    commit_data = d;
    if (keep) push_record(pc, rg, d);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_ready = 1'b0; commit_en = 1'b0;
    step(); step();
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", tx_data); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    tests++; if (drop_cnt !== 16'h0) begin fails++; $display("FAIL rst_drop_cnt: got %h want 0000", drop_cnt); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int first;
    tx_ready = 1'b1;
    drive_commit(32'h0000_3000, 5'd8, 32'h1234_5678, 1'b1);
    commit_en = 1'b0;
    @(negedge clk);
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty_fall: got %b want 0", empty); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b want 0", tx_valid); end
    step();
    first = -1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (first < 0) first = c;
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL single_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL single_timeout: %0d bytes missing, want 0", sb.size()); end
    tests++; if (first != 0) begin fails++; $display("FAIL single_latency: first byte at cycle %0d want 0", first); end
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_idle_valid: got %b want 0", tx_valid); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_idle_empty: got %b want 1", empty); end
    step();
  endtask

  task automatic test_back_to_back();
    int first, last;
    tx_ready = 1'b1;
    drive_commit(32'h0040_0010, 5'd2, 32'hA5A5_0001, 1'b1);
    drive_commit(32'h0040_0014, 5'd31, 32'h5A5A_0002, 1'b1);
    commit_en = 1'b0;
    first = -1; last = -1;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (first < 0) first = c;
        last = c;
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL b2b_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_timeout: %0d bytes missing, want 0", sb.size()); end
    tests++; if (last - first != 17) begin fails++; $display("FAIL b2b_gapless: span %0d cycles want 17", last - first); end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_commit({8'(8'h40 + i), 8'h5A, 8'h00, 8'(i * 4)}, 5'(i + 1), $urandom, i < DEPTH + 1);
    end
    commit_en = 1'b0;
    @(negedge clk);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b want 1", full); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b want 1", tx_valid); end
    tests++; if (tx_data !== 8'h40) begin fails++; $display("FAIL ovf_hold0: got %h want 40", tx_data); end
    step(); step();
    @(negedge clk);
    tests++; if (tx_data !== 8'h40) begin fails++; $display("FAIL ovf_hold1: got %h want 40", tx_data); end
    step();
    tx_ready = 1'b1;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL ovf_drain_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL ovf_timeout: %0d bytes missing, want 0", sb.size()); end
    @(negedge clk);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty_after: got %b want 1", empty); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    step();
  endtask

  task automatic test_toggle_ready();
    tx_ready = 1'b0;
    drive_commit(32'h1357_9BDF, 5'd17, 32'h0246_8ACE, 1'b1);
    commit_en = 1'b0;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL toggle_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
      tx_ready = ~tx_ready;
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL toggle_timeout: %0d bytes missing, want 0", sb.size()); end
    tx_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int got;
    tx_ready = 1'b1;
    drive_commit(32'hCAFE_0100, 5'd3, 32'hDEAD_BEEF, 1'b1);
    commit_en = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_b = sb.pop_front();
        got++;
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL rmid_pre_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    reset = 1'b0;
    step();
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h want 00", tx_data); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rmid_empty: got %b want 1", empty); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
    tests++; if (drop_cnt !== 16'h0) begin fails++; $display("FAIL rmid_drop_cnt: got %h want 0000", drop_cnt); end
    reset = 1'b1;
    sb.delete();
    step();
    drive_commit(32'h0000_4008, 5'd9, 32'h0BAD_F00D, 1'b1);
    commit_en = 1'b0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL rmid_post_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL rmid_timeout: %0d bytes missing, want 0", sb.size()); end
  endtask

  task automatic test_r0();
    tx_ready = 1'b1;
`ifdef TRACE_FILTER_R0_EN
    drive_commit(32'h0000_3004, 5'd0, 32'hFFFF_FFFF, 1'b0);
    commit_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++; if (empty !== 1'b1 || tx_valid !== 1'b0) begin
        fails++; $display("FAIL r0_filtered: empty=%b valid=%b want 1/0", empty, tx_valid);
      end
      step();
    end
`else
    drive_commit(32'h0000_3004, 5'd0, 32'hFFFF_FFFF, 1'b1);
    commit_en = 1'b0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_b = sb.pop_front();
        tests++; if (tx_data !== exp_b) begin fails++; $display("FAIL r0_byte: got %h want %h", tx_data, exp_b); end
      end
      step();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL r0_timeout: %0d bytes missing, want 0", sb.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_toggle_ready();
    test_reset_mid();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/commit_trace_tx.md
# commit_trace_tx

Register-writeback trace transmitter for the single-cycle MIPS core. Each architectural register write (PC, destination register, value) is captured on the cycle it commits and buffered in a FIFO. Records are serialized onto an 8-bit valid/ready byte stream for an off-core logger or UART bridge. This is the hardware producer of the same per-cycle register-state information the CPU bench dumps from `regfiles`. It instantiates beside `regfiles` inside `cpu`.

## Interface
- `DEPTH`, 16, FIFO record capacity; power of two, ≥2.
- `AW`, 4, FIFO pointer width, log2(DEPTH).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `commit_en`  in  1  register write commits this cycle (same qualifier as `regfiles` write enable).
- `commit_pc`  in  32  byte PC of the committing instruction.
- `commit_reg`  in  5  destination register number.
- `commit_data`  in  32  value written.
- `tx_data`  out  8  current stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  consumer accepts the byte on this edge when `tx_valid` is also high.
- `full`  out  1  FIFO holds DEPTH records.
- `empty`  out  1  FIFO holds 0 records.
- `overflow`  out  1  sticky; a commit was dropped since reset.
- `drop_cnt`  out  16  dropped commits, saturating at 16'hFFFF.

## Operation
**Reset behaviour**
- On a clock edge with `reset`=0, the block resets. Pointers and count go to 0.
- Reset outputs: `empty`=1, `full`=0, `tx_valid`=0, `tx_data`=8'h00, `overflow`=0, `drop_cnt`=0.
- Serializer returns to IDLE and any partial record is abandoned. Reset mid-record is legal.

**Record format**
- 9 bytes, sent in this order:
  - `commit_pc[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`
  - `{3'b000, commit_reg}`
  - `commit_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`

**Push**
- A commit is pushed when `commit_en`=1 and count<DEPTH. The write pointer wraps modulo DEPTH.
- If count==DEPTH, the commit is dropped, even if a pop occurs on the same edge.
- On a drop: `overflow`←1 and `drop_cnt` increments unless it is already 16'hFFFF.

**Serializer FSM** (states IDLE, SEND; byte index `idx` 0..8)
- IDLE: if count>0, pop the head record into a 72-bit shift register, set `idx`=0, and go to SEND.
- SEND: `tx_valid`=1 and `tx_data`=byte `idx`.
  - On `tx_valid && tx_ready`: if `idx`<8, increment `idx`.
  - If `idx`==8 and count>0: pop the next record, set `idx`=0, stay in SEND (no bubble).
  - If `idx`==8 and count==0: go to IDLE.
- While `tx_ready`=0, `tx_data` and `tx_valid` hold stable.

**Count and flags**
- count = count + push − pop. A simultaneous push and pop leaves count unchanged.
- `full` and `empty` are registered and decoded from the next value of count.

## Timing
- Push at edge E: `empty` falls after E.
- If the serializer is in IDLE, the pop happens at edge E+1, and `tx_valid` rises after E+1 with byte 0.
- Minimum commit-to-first-byte latency: 2 edges.
- With `tx_ready` held at 1, a record takes 9 cycles. Sustained throughput is 1 commit per 9 cycles, so a burst longer than DEPTH + ⌊burst/9⌋ overflows.
- The popped record occupies the shift register, not a FIFO slot. Total buffering is therefore DEPTH+1 records.
- `tx_data` and `tx_valid` are registered outputs with no combinational path from `tx_ready`.

## Configuration
- `TRACE_FILTER_R0_EN` defined: commits with `commit_reg`==0 are discarded silently. They are not pushed, not counted in `drop_cnt`, and do not set `overflow`.
- `TRACE_FILTER_R0_EN` undefined: $0 writes are recorded like any other register.

## Test plan
- Reset, then a single commit pc=32'h0000_3000, reg=8, data=32'h1234_5678 with `tx_ready`=1. Expected: `tx_valid` rises 2 edges after the push, and the bytes are 00 00 30 00 08 12 34 56 78. Then `tx_valid`=0 and `empty`=1.
- Two back-to-back commits with `tx_ready`=1. Expected: 18 consecutive valid bytes with no idle cycle between records.
- `tx_ready`=0 while DEPTH+2 commits arrive. Expected:
  - 1 record goes to the shift register and DEPTH records fill the FIFO, so `full`=1.
  - The last commit is dropped: `overflow`=1, `drop_cnt`=1.
  - `tx_data` is held at byte 0 of the first record.
  - Draining with `tx_ready`=1 delivers DEPTH+1 records in order.
- Toggle `tx_ready` every cycle during a record. Expected: each byte is accepted exactly once and the sequence is unchanged.
- Pull `reset` low during byte 4. Expected: on the next edge all outputs take their reset values. The next commit's output starts at byte 0 of the new record.
- Commit reg=0, data=32'hFFFF_FFFF. Expected: with `TRACE_FILTER_R0_EN` defined there is no output and `empty` stays 1. Without it, a 9-byte record with reg byte 00 is sent.
